// File: rtl/axi4_lite_master.sv
// axi4_lite_master: serialises one command at a time into AXI4-Lite write/read transactions.
// Optional AXIL_MASTER_STATS_EN adds saturating 16-bit handshake/error counters.
module axi4_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
`ifdef AXIL_MASTER_STATS_EN
  output logic [15:0]                     stat_wr_count,
  output logic [15:0]                     stat_rd_count,
  output logic [15:0]                     stat_err_count,
`endif
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  state_t state, state_n;
  logic accept, aw_left, w_left, b_hs, r_hs;
  assign accept = cmd_valid && cmd_ready;
  assign aw_left = M_AXI_AWVALID && !M_AXI_AWREADY;
  assign w_left = M_AXI_WVALID && !M_AXI_WREADY;
  assign b_hs = M_AXI_BVALID && M_AXI_BREADY;
  assign r_hs = M_AXI_RVALID && M_AXI_RREADY;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_n = (aw_left || w_left) ? WR_REQ : WR_RESP;
      WR_RESP: state_n = M_AXI_BVALID ? RSP : WR_RESP;
      RD_REQ:  state_n = M_AXI_ARREADY ? RD_RESP : RD_REQ;
      RD_RESP: state_n = M_AXI_RVALID ? RSP : RD_RESP;
      RSP:     state_n = rsp_ready ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
  end
  // AW and W valids are separate flops so each can retire on its own handshake
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_resp      <= 2'b00;
      rsp_rdata     <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      state         <= state_n;
      cmd_ready     <= state_n == IDLE;
      M_AXI_AWVALID <= (accept && cmd_write) || aw_left;
      M_AXI_WVALID  <= (accept && cmd_write) || w_left;
      M_AXI_BREADY  <= state_n == WR_RESP;
      M_AXI_ARVALID <= state_n == RD_REQ;
      M_AXI_RREADY  <= state_n == RD_RESP;
      rsp_valid     <= state_n == RSP;
      if (accept) begin
        M_AXI_AWADDR <= cmd_addr;
        M_AXI_ARADDR <= cmd_addr;
        M_AXI_WDATA  <= cmd_wdata;
        M_AXI_WSTRB  <= cmd_wstrb;
      end
      if (b_hs) begin
        rsp_write <= 1'b1;
        rsp_resp  <= M_AXI_BRESP;
        rsp_rdata <= '0;
      end
      if (r_hs) begin
        rsp_write <= 1'b0;
        rsp_resp  <= M_AXI_RRESP;
        rsp_rdata <= M_AXI_RDATA;
      end
    end
  end
`ifdef AXIL_MASTER_STATS_EN
  logic err_hs;
  assign err_hs = (b_hs && M_AXI_BRESP != 2'b00) || (r_hs && M_AXI_RRESP != 2'b00);
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      stat_wr_count  <= '0;
      stat_rd_count  <= '0;
      stat_err_count <= '0;
    end else begin
      if (b_hs && stat_wr_count != 16'hFFFF) stat_wr_count <= stat_wr_count + 16'd1;
      if (r_hs && stat_rd_count != 16'hFFFF) stat_rd_count <= stat_rd_count + 16'd1;
      if (err_hs && stat_err_count != 16'hFFFF) stat_err_count <= stat_err_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed bench with a 4-register slave model and a manual stub slave mode.
module tb_axi4_lite_master;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0] cmd_addr = 0, cmd_wstrb = 0;
  logic [31:0] cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_write;
  logic [1:0] rsp_resp;
  logic [31:0] rsp_rdata;
  logic [3:0] awaddr, araddr, wstrb;
  logic [2:0] awprot, arprot;
  logic [31:0] wdata;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
`ifdef AXIL_MASTER_STATS_EN
  logic [15:0] stat_wr_count, stat_rd_count, stat_err_count;
`endif
  logic stub = 0, t_awready = 0, t_wready = 0, t_bvalid = 0;
  logic [1:0] t_bresp = 0;
  logic s_awready = 0, s_wready = 0, s_bvalid = 0, s_arready = 0, s_rvalid = 0;
  logic [1:0] s_bresp = 0, s_rresp = 0;
  logic [31:0] s_rdata = 0;
  logic [31:0] regs [4] = '{4{32'h0}};
  int errors = 0, checks = 0, exp_wr = 0, exp_rd = 0, exp_err = 0;

  assign awready = stub ? t_awready : s_awready;
  assign wready  = stub ? t_wready  : s_wready;
  assign bvalid  = stub ? t_bvalid  : s_bvalid;
  assign bresp   = stub ? t_bresp   : s_bresp;
  assign arready = stub ? 1'b0      : s_arready;
  assign rvalid  = stub ? 1'b0      : s_rvalid;
  assign rresp   = s_rresp;
  assign rdata   = s_rdata;

  axi4_lite_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
`ifdef AXIL_MASTER_STATS_EN
    .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Team slave: ready one cycle after seeing both AW and W (or AR), response the cycle after
  always @(posedge clk) begin
    if (!stub) begin
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_arready <= 1'b0;
      if (awvalid && wvalid && !s_awready && !s_bvalid) begin
        s_awready <= 1'b1;
        s_wready  <= 1'b1;
        s_bresp   <= (awaddr[1:0] == 2'b00) ? 2'b00 : 2'b11;
        if (awaddr[1:0] == 2'b00)
          for (int i = 0; i < 4; i++)
            if (wstrb[i]) regs[awaddr[3:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (s_awready) s_bvalid <= 1'b1;
      if (s_bvalid && bready) s_bvalid <= 1'b0;
      if (arvalid && !s_arready && !s_rvalid) begin
        s_arready <= 1'b1;
        s_rresp   <= (araddr[1:0] == 2'b00) ? 2'b00 : 2'b11;
        s_rdata   <= (araddr[1:0] == 2'b00) ? regs[araddr[3:2]] : 32'hDEADDEAD;
      end
      if (s_arready) s_rvalid <= 1'b1;
      if (s_rvalid && rready) s_rvalid <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with cmd_ready high; checks the N+1 request and N+4 response cadence
  task automatic txn(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [1:0] er, input logic [31:0] ed);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 0;
    chk("req", 64'({awvalid, wvalid, arvalid, cmd_ready, w ? awaddr : araddr, awprot, arprot}),
        64'({w, w, !w, 1'b0, a, 6'b0}));
    if (w) chk("wdata", 64'({wstrb, wdata}), 64'({s, d}));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}), 64'({1'b1, w, er, ed}));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    if (w) exp_wr++; else exp_rd++;
    if (er != 2'b00) exp_err++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({cmd_ready, rsp_valid, rsp_write, rsp_resp, awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("rst_data", 64'({awaddr, araddr, wstrb, rsp_rdata}), 64'(0));
    rstn = 1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready), 64'(1));
    txn(1, 4'h4, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0);
    txn(0, 4'h4, 32'h0, 4'h0, 2'b00, 32'hA5A5_1234);
    txn(1, 4'h8, 32'h1122_3344, 4'hF, 2'b00, 32'h0);
    txn(1, 4'h8, 32'hFFFF_BEEF, 4'b0011, 2'b00, 32'h0);
    txn(0, 4'h8, 32'h0, 4'h0, 2'b00, 32'h1122_BEEF);
    txn(0, 4'h2, 32'h0, 4'h0, 2'b11, 32'hDEAD_DEAD);
    txn(1, 4'hC, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0);
    txn(0, 4'hC, 32'h0, 4'h0, 2'b00, 32'h0);
    // Stub slave: WREADY three cycles ahead of AWREADY, BVALID five cycles late with SLVERR
    stub = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0; cmd_wdata = 32'h0000_55AA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0; t_wready = 1;
    chk("stub_both_valid", 64'({awvalid, wvalid}), 64'(2'b11));
    @(negedge clk);
    t_wready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stub_aw_held", 64'({awvalid, wvalid, bready, awaddr}), 64'({3'b100, 4'h0}));
      if (i < 2) @(negedge clk);
    end
    t_awready = 1;
    @(negedge clk);
    t_awready = 0;
    for (int i = 0; i < 5; i++) begin
      chk("stub_b_wait", 64'({awvalid, wvalid, bready, rsp_valid}), 64'(4'b0010));
      @(negedge clk);
    end
    t_bvalid = 1; t_bresp = 2'b10;
    @(negedge clk);
    t_bvalid = 0; t_bresp = 2'b00;
    chk("stub_rsp", 64'({rsp_valid, rsp_write, rsp_resp, bready, rsp_rdata}), 64'({4'b1110, 1'b0, 32'h0}));
    rsp_ready = 1;
    exp_wr++; exp_err++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stub_one_rsp", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    end
    rsp_ready = 0; stub = 0;
    // Requester back-pressure for ten cycles
    cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h4;
    @(negedge clk);
    cmd_valid = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("rsp_hold", 64'({rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_rdata}), 64'({5'b10000, 32'hA5A5_1234}));
      @(negedge clk);
    end
    rsp_ready = 1;
    exp_rd++;
    @(negedge clk);
    rsp_ready = 0;
    chk("hold_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
`ifdef AXIL_MASTER_STATS_EN
    chk("stats", 64'({stat_wr_count, stat_rd_count, stat_err_count}), 64'({16'(exp_wr), 16'(exp_rd), 16'(exp_err)}));
`endif
    // Reset pulsed while waiting in WR_RESP
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("in_wr_resp", 64'({bready, rsp_valid}), 64'(2'b10));
    rstn = 0;
    @(negedge clk);
    chk("mid_rst_ctl", 64'({cmd_ready, rsp_valid, rsp_write, rsp_resp, awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    chk("mid_rst_addr", 64'({awaddr, araddr, wstrb}), 64'(0));
    chk("mid_rst_wdata", 64'(wdata), 64'(0));
`ifdef AXIL_MASTER_STATS_EN
    chk("mid_rst_stats", 64'({stat_wr_count, stat_rd_count, stat_err_count}), 64'(0));
`endif
    rstn = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'({cmd_ready, rsp_valid, bready}), 64'(3'b100));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
